// File: rtl/sort_pru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sort_pru_pkg
// Description : Shared widths, types, FSM state encoding and scan-direction
//               constants for the PRU tile-occupancy scan stage.
//               Optional macro SORT_PRU_DESCEND_EN selects a descending scan
//               (SORT_PERF_SBU_NUM-1 down to 0) instead of ascending.
// Revision    : 1.0  initial release
// ============================================================================
package sort_pru_pkg;

    localparam int SORT_FUC_MAX_NUM       = 256;
    localparam int SORT_PERF_SBU_TILE_NUM = 8;
    // Must be a power of two and at least 2 so the pointer wraps cleanly.
    localparam int SORT_PERF_SBU_NUM      = SORT_FUC_MAX_NUM / SORT_PERF_SBU_TILE_NUM;
    localparam int SORT_FUC_SBU_ADDR_W    = $clog2(SORT_PERF_SBU_NUM);
    // One extra bit so a completely full map (SORT_PERF_SBU_NUM hits) fits.
    localparam int SORT_PRU_CNT_W         = SORT_FUC_SBU_ADDR_W + 1;

    typedef logic [SORT_FUC_SBU_ADDR_W-1:0] sbu_addr_t;
    typedef logic [SORT_PRU_CNT_W-1:0]      hit_cnt_t;

    localparam hit_cnt_t HIT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } pru_state_t;

`ifdef SORT_PRU_DESCEND_EN
    localparam sbu_addr_t SCAN_FIRST_ADDR = sbu_addr_t'(SORT_PERF_SBU_NUM - 1);
    localparam sbu_addr_t SCAN_LAST_ADDR  = '0;
    localparam bit        SCAN_DESCEND    = 1'b1;
`else
    localparam sbu_addr_t SCAN_FIRST_ADDR = '0;
    localparam sbu_addr_t SCAN_LAST_ADDR  = sbu_addr_t'(SORT_PERF_SBU_NUM - 1);
    localparam bit        SCAN_DESCEND    = 1'b0;
`endif

    // Next scan address in the configured direction.
    function automatic sbu_addr_t scan_next(input sbu_addr_t addr);
        if (SCAN_DESCEND)
            return addr - sbu_addr_t'(1);
        else
            return addr + sbu_addr_t'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sort_pru_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_pru_scan_if
// Description : Bus bundle of the PRU scan stage.
//               - pru2sbu_rd_*  : read-and-clear request into the SBU bitmap
//               - sbu2pru_rd_*  : same-cycle read return from the SBU
//               - pru_out_*     : valid/ready stream of occupied tile addresses
//               modport master : PRU side; modport slave : SBU/downstream side.
// Revision    : 1.0  initial release
// ============================================================================
interface sort_pru_scan_if;
    import sort_pru_pkg::*;

    logic      pru2sbu_rd_vld;
    sbu_addr_t pru2sbu_rd_addr;
    logic      sbu2pru_rd_vld;
    sbu_addr_t sbu2pru_rd_addr;
    logic      sbu2pru_rd_data;
    logic      pru_out_vld;
    sbu_addr_t pru_out_addr;
    logic      pru_out_rdy;

    modport master (
        output pru2sbu_rd_vld,
        output pru2sbu_rd_addr,
        input  sbu2pru_rd_vld,
        input  sbu2pru_rd_addr,
        input  sbu2pru_rd_data,
        output pru_out_vld,
        output pru_out_addr,
        input  pru_out_rdy
    );

    modport slave (
        input  pru2sbu_rd_vld,
        input  pru2sbu_rd_addr,
        output sbu2pru_rd_vld,
        output sbu2pru_rd_addr,
        output sbu2pru_rd_data,
        input  pru_out_vld,
        input  pru_out_addr,
        output pru_out_rdy
    );

endinterface
`default_nettype wire

// File: rtl/sort_pru_obuf.sv
`default_nettype none
// ============================================================================
// Module      : sort_pru_obuf
// Description : Single-entry valid/ready output register. A load in the same
//               cycle as a pop refills the slot with no bubble.
// Ports       : clk, rst (async, active-low)
//               load_i / load_addr_i : write a new occupied tile address
//               rdy_i                : downstream ready (pop = vld_o & rdy_i)
//               vld_o / addr_o       : registered output entry
//               empty_o              : slot free
// Revision    : 1.0  initial release
// ============================================================================
module sort_pru_obuf
    import sort_pru_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      load_i,
    input  sbu_addr_t load_addr_i,
    input  logic      rdy_i,
    output logic      vld_o,
    output sbu_addr_t addr_o,
    output logic      empty_o
);

    logic      vld_q;
    logic      vld_d;
    logic      vld_en;
    sbu_addr_t addr_q;
    logic      w_pop;

    assign w_pop = vld_q & rdy_i;

    // The upstream only loads when the slot is free or being popped, so the
    // next valid is simply whether a load arrived.
    always_comb begin
        vld_en = load_i | w_pop;
        vld_d  = load_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld_q <= 1'b0;
        else if (vld_en)
            vld_q <= vld_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            addr_q <= '0;
        else if (load_i)
            addr_q <= load_addr_i;
    end

    assign vld_o   = vld_q;
    assign addr_o  = addr_q;
    assign empty_o = ~vld_q;

endmodule
`default_nettype wire

// File: rtl/sort_pru_scan.sv
`default_nettype none
// ============================================================================
// Module      : sort_pru_scan
// Description : Sequentially reads (and thereby clears) every SBU occupancy
//               bit after a start pulse and streams the occupied tile
//               addresses downstream in scan order.
//               Optional macro SORT_PRU_DESCEND_EN : scan from the top
//               address down to 0 (descending output order).
// Ports       : clk, rst (async, active-low), start_i
//               bus (master) : SBU read port + output stream
//               pru_hit_cnt_o: hits in the current/last scan (saturating)
//               pru_busy_o   : scanning or draining
//               pru_done_o   : one-cycle pulse once the last hit has left
// Revision    : 1.0  initial release
// ============================================================================
module sort_pru_scan
    import sort_pru_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    sort_pru_scan_if.master bus,
    output hit_cnt_t        pru_hit_cnt_o,
    output logic            pru_busy_o,
    output logic            pru_done_o
);

    pru_state_t state_q;
    pru_state_t state_d;
    sbu_addr_t  ptr_q;
    sbu_addr_t  ptr_d;
    logic       ptr_en;
    hit_cnt_t   cnt_q;
    hit_cnt_t   cnt_d;
    logic       cnt_en;

    logic       w_cnt_clr;
    logic       w_done;
    logic       w_buf_empty;
    logic       w_rd_issue;
    logic       w_hit;
    logic       w_out_vld;
    sbu_addr_t  w_out_addr;

    // Every SBU read clears the bit, so a read may only go out when its hit
    // is guaranteed a place in the output register this cycle.
    assign w_rd_issue = (state_q == ST_SCAN) && (w_buf_empty || bus.pru_out_rdy);

    // Returns without a matching request are ignored.
    assign w_hit = w_rd_issue && bus.sbu2pru_rd_vld && bus.sbu2pru_rd_data;

    // ------------------------------------------------------------------------
    // State / pointer / hit counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr_q <= '0;
        else if (ptr_en)
            ptr_q <= ptr_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (cnt_en)
            cnt_q <= cnt_d;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        ptr_en    = 1'b0;
        w_cnt_clr = 1'b0;
        w_done    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d   = ST_SCAN;
                    ptr_d     = SCAN_FIRST_ADDR;
                    ptr_en    = 1'b1;
                    w_cnt_clr = 1'b1;
                end
            end

            ST_SCAN: begin
                if (w_rd_issue) begin
                    ptr_d  = scan_next(ptr_q);
                    ptr_en = 1'b1;
                    if (ptr_q == SCAN_LAST_ADDR)
                        state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                // Done is flagged in the first cycle the buffer is seen empty.
                if (w_buf_empty) begin
                    w_done  = 1'b1;
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Clear has priority; a hit can never coincide with a clear because hits
    // only occur in SCAN.
    always_comb begin
        cnt_d  = cnt_q;
        cnt_en = 1'b0;
        if (w_cnt_clr) begin
            cnt_d  = '0;
            cnt_en = 1'b1;
        end else if (w_hit && (cnt_q != HIT_CNT_MAX)) begin
            cnt_d  = cnt_q + hit_cnt_t'(1);
            cnt_en = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------------
    sort_pru_obuf u_obuf (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_hit),
        .load_addr_i (bus.sbu2pru_rd_addr),
        .rdy_i       (bus.pru_out_rdy),
        .vld_o       (w_out_vld),
        .addr_o      (w_out_addr),
        .empty_o     (w_buf_empty)
    );

    assign bus.pru2sbu_rd_vld  = w_rd_issue;
    assign bus.pru2sbu_rd_addr = ptr_q;
    assign bus.pru_out_vld     = w_out_vld;
    assign bus.pru_out_addr    = w_out_addr;

    assign pru_hit_cnt_o = cnt_q;
    assign pru_busy_o    = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
    assign pru_done_o    = w_done;

endmodule
`default_nettype wire
